// File: rtl/lsu_pkg.sv
// Shared types and constants for the load/store initiator: FSM states,
// RISC-V load/store funct3 codes and the data-memory port command codes.
package lsu_pkg;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_READ  = 2'd1,
    ST_WRITE = 2'd2,
    ST_RESP  = 2'd3
  } lsu_state_e;

  localparam logic [2:0] F3_B  = 3'b000;
  localparam logic [2:0] F3_H  = 3'b001;
  localparam logic [2:0] F3_W  = 3'b010;
  localparam logic [2:0] F3_BU = 3'b100;
  localparam logic [2:0] F3_HU = 3'b101;

  localparam logic [2:0] MEM_NONE = 3'b000;
  localparam logic [2:0] MEM_LW   = 3'b101;
  localparam logic [2:0] MEM_SW   = 3'b100;

  // Stores only exist as B/H/W; the unsigned forms are load-only.
  function automatic logic f3_legal(input logic we, input logic [2:0] f3);
    case (f3)
      F3_B, F3_H, F3_W: f3_legal = 1'b1;
      F3_BU, F3_HU:     f3_legal = ~we;
      default:          f3_legal = 1'b0;
    endcase
  endfunction

endpackage

// File: rtl/lsu_lane_align.sv
// Byte-lane steering: load extraction with sign/zero extension, and the
// sub-word merge used for the read-modify-write of SB/SH.
module lsu_lane_align
  import lsu_pkg::*;
(
  input  logic [31:0] word,
  input  logic [1:0]  lane,
  input  logic [2:0]  funct3,
  input  logic [31:0] new_data,
  output logic [31:0] load_data,
  output logic [31:0] store_data
);

  logic [4:0]  shamt_s;
  logic [31:0] shifted_s;
  logic [31:0] mask_s;

  assign shamt_s   = {lane, 3'b000};
  assign shifted_s = word >> shamt_s;

  // Load extraction from the addressed lane.
  always_comb begin
    load_data = 32'h0000_0000;
    case (funct3)
      F3_B:    load_data = {{24{shifted_s[7]}}, shifted_s[7:0]};
      F3_H:    load_data = {{16{shifted_s[15]}}, shifted_s[15:0]};
      F3_W:    load_data = word;
      F3_BU:   load_data = {24'h00_0000, shifted_s[7:0]};
      F3_HU:   load_data = {16'h0000, shifted_s[15:0]};
      default: load_data = 32'h0000_0000;
    endcase
  end

  // Lane mask for the store merge; a word store replaces everything.
  always_comb begin
    mask_s = 32'hFFFF_FFFF;
    case (funct3)
      F3_B:    mask_s = 32'h0000_00FF;
      F3_H:    mask_s = 32'h0000_FFFF;
      default: mask_s = 32'hFFFF_FFFF;
    endcase
  end

  assign store_data = (word & ~(mask_s << shamt_s)) | ((new_data & mask_s) << shamt_s);

endmodule

// File: rtl/lsu_master.sv
// Load/store initiator between the MEM stage and a word-wide data memory.
// Build option LSU_MISALIGN_TRAP_EN: trap misaligned H/W instead of truncating the address.
module lsu_master
  import lsu_pkg::*;
#(
  parameter logic [31:0] BASE_ADDR = 32'h8000_0000,
  parameter int unsigned MEM_BYTES = 32'd32768
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        req_valid_i,
  output logic        req_ready_o,
  input  logic        req_we_i,
  input  logic [2:0]  req_funct3_i,
  input  logic [31:0] req_addr_i,
  input  logic [31:0] req_wdata_i,
  output logic        resp_valid_o,
  output logic [31:0] resp_rdata_o,
  output logic        resp_err_o,
  output logic [2:0]  mem_read_o,
  output logic [2:0]  mem_write_o,
  output logic [31:0] mem_addr_o,
  input  logic [31:0] mem_rdata_i,
  output logic [31:0] mem_wdata_o
);

  lsu_state_e  state_r, next_s;
  logic        we_r;
  logic [2:0]  f3_r;
  logic [1:0]  lane_r;
  logic [31:0] word_addr_r, wdata_r;

  logic        ready_r, resp_valid_r, resp_err_r;
  logic [31:0] resp_rdata_r, mem_addr_r, mem_wdata_r;
  logic [2:0]  mem_read_r, mem_write_r;

  logic        size_h_s, size_w_s, in_range_s, align_err_s, req_err_s;
  logic [31:0] offset_s, addr_next_s, wdata_next_s, rdata_next_s;
  logic [1:0]  eff_lane_s;
  logic        err_next_s;
  logic [31:0] load_data_s, store_data_s;

  assign size_h_s   = (req_funct3_i[1:0] == 2'b01);
  assign size_w_s   = (req_funct3_i[1:0] == 2'b10);
  // Subtract first so an address below the base wraps high and fails the bound.
  assign offset_s   = req_addr_i - BASE_ADDR;
  assign in_range_s = (req_addr_i >= BASE_ADDR) && (offset_s < MEM_BYTES);

`ifdef LSU_MISALIGN_TRAP_EN
  assign align_err_s = (size_h_s & req_addr_i[0]) | (size_w_s & (req_addr_i[1:0] != 2'b00));
`else
  assign align_err_s = 1'b0;
`endif

  assign req_err_s = ~f3_legal(req_we_i, req_funct3_i) | ~in_range_s | align_err_s;

  // Effective lane with misaligned low bits dropped for H and W.
  always_comb begin
    eff_lane_s = req_addr_i[1:0];
    if (size_w_s) begin
      eff_lane_s = 2'b00;
    end else if (size_h_s) begin
      eff_lane_s = {req_addr_i[1], 1'b0};
    end else begin
      eff_lane_s = req_addr_i[1:0];
    end
  end

  lsu_lane_align u_align (
    .word       (mem_rdata_i),
    .lane       (lane_r),
    .funct3     (f3_r),
    .new_data   (wdata_r),
    .load_data  (load_data_s),
    .store_data (store_data_s)
  );

  // Next state plus the values the registered outputs take on entry to it.
  always_comb begin
    next_s       = state_r;
    addr_next_s  = word_addr_r;
    wdata_next_s = 32'h0000_0000;
    rdata_next_s = 32'h0000_0000;
    err_next_s   = 1'b0;
    case (state_r)
      ST_IDLE: begin
        addr_next_s  = {req_addr_i[31:2], 2'b00};
        wdata_next_s = req_wdata_i;
        if (req_valid_i) begin
          if (req_err_s) begin
            next_s     = ST_RESP;
            err_next_s = 1'b1;
          end else if (req_we_i && (req_funct3_i == F3_W)) begin
            next_s = ST_WRITE;
          end else begin
            next_s = ST_READ;
          end
        end else begin
          next_s = ST_IDLE;
        end
      end
      ST_READ: begin
        wdata_next_s = store_data_s;
        rdata_next_s = load_data_s;
        if (we_r) begin
          next_s = ST_WRITE;
        end else begin
          next_s = ST_RESP;
        end
      end
      ST_WRITE: next_s = ST_RESP;
      ST_RESP:  next_s = ST_IDLE;
      default:  next_s = ST_IDLE;
    endcase
  end

  // State register and request capture on the IDLE handshake.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_r     <= ST_IDLE;
      we_r        <= 1'b0;
      f3_r        <= 3'b000;
      lane_r      <= 2'b00;
      word_addr_r <= 32'h0000_0000;
      wdata_r     <= 32'h0000_0000;
    end else begin
      state_r <= next_s;
      if ((state_r == ST_IDLE) && req_valid_i) begin
        we_r        <= req_we_i;
        f3_r        <= req_funct3_i;
        lane_r      <= eff_lane_s;
        word_addr_r <= {req_addr_i[31:2], 2'b00};
        wdata_r     <= req_wdata_i;
      end
    end
  end

  // Output registers, loaded from the state being entered.
  always_ff @(posedge clk) begin
    if (rst) begin
      ready_r      <= 1'b1;
      mem_read_r   <= MEM_NONE;
      mem_write_r  <= MEM_NONE;
      mem_addr_r   <= 32'h0000_0000;
      mem_wdata_r  <= 32'h0000_0000;
      resp_valid_r <= 1'b0;
      resp_err_r   <= 1'b0;
      resp_rdata_r <= 32'h0000_0000;
    end else begin
      ready_r      <= (next_s == ST_IDLE);
      mem_read_r   <= (next_s == ST_READ) ? MEM_LW : MEM_NONE;
      mem_write_r  <= (next_s == ST_WRITE) ? MEM_SW : MEM_NONE;
      mem_addr_r   <= ((next_s == ST_READ) || (next_s == ST_WRITE)) ? addr_next_s : 32'h0000_0000;
      mem_wdata_r  <= (next_s == ST_WRITE) ? wdata_next_s : 32'h0000_0000;
      resp_valid_r <= (next_s == ST_RESP);
      resp_err_r   <= (next_s == ST_RESP) & err_next_s;
      resp_rdata_r <= (next_s == ST_RESP) ? rdata_next_s : 32'h0000_0000;
    end
  end

  assign req_ready_o  = ready_r;
  assign mem_read_o   = mem_read_r;
  assign mem_write_o  = mem_write_r;
  assign mem_addr_o   = mem_addr_r;
  assign mem_wdata_o  = mem_wdata_r;
  assign resp_valid_o = resp_valid_r;
  assign resp_err_o   = resp_err_r;
  assign resp_rdata_o = resp_rdata_r;

endmodule

// File: tb/tb_lsu_master.sv
// Randomized bench for lsu_master against a byte-array reference memory;
// honours LSU_MISALIGN_TRAP_EN the same way the design does.
module tb_lsu_master;

  localparam logic [31:0] BASE      = 32'h8000_0000;
  localparam int unsigned MEM_BYTES = 32768;
`ifdef LSU_MISALIGN_TRAP_EN
  localparam bit TRAP = 1'b1;
`else
  localparam bit TRAP = 1'b0;
`endif

  logic        clk, rst;
  logic        req_valid, req_ready, req_we;
  logic [2:0]  req_funct3;
  logic [31:0] req_addr, req_wdata;
  logic        resp_valid, resp_err;
  logic [31:0] resp_rdata;
  logic [2:0]  mem_read, mem_write;
  logic [31:0] mem_addr, mem_rdata, mem_wdata;

  lsu_master dut (
    .clk          (clk),
    .rst          (rst),
    .req_valid_i  (req_valid),
    .req_ready_o  (req_ready),
    .req_we_i     (req_we),
    .req_funct3_i (req_funct3),
    .req_addr_i   (req_addr),
    .req_wdata_i  (req_wdata),
    .resp_valid_o (resp_valid),
    .resp_rdata_o (resp_rdata),
    .resp_err_o   (resp_err),
    .mem_read_o   (mem_read),
    .mem_write_o  (mem_write),
    .mem_addr_o   (mem_addr),
    .mem_rdata_i  (mem_rdata),
    .mem_wdata_o  (mem_wdata)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  function automatic logic [31:0] init_word(input int i);
    logic [31:0] w;
    w = (i == 4) ? 32'hAABB_CCDD : ((i * 32'h9E37_79B1) ^ 32'h5A5A_0F0F);
    return w;
  endfunction

  // Memory seen by the DUT.
  logic [31:0] dmem [0:8191];
  logic        init_pulse;
  assign mem_rdata = dmem[mem_addr[14:2]];
  always @(posedge clk) begin
    if (init_pulse) begin
      for (int i = 0; i < 8192; i++) dmem[i] <= init_word(i);
    end else if (mem_write == 3'b100) begin
      dmem[mem_addr[14:2]] <= mem_wdata;
    end
  end

  // Reference memory kept as bytes.
  logic [7:0] ref_mem [0:32767];

  int unsigned n_err = 0;
  int unsigned n_chk = 0;

  task automatic check_val(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_chk++;
    if (obs !== exp) begin
      n_err++;
      $display("FAIL %s: got %h expected %h", tag, obs, exp);
    end
  endtask

  task automatic run_txn(input logic we, input logic [2:0] f3, input logic [31:0] addr,
                         input logic [31:0] wd);
    logic [31:0] sz, eff, exp_rd, exp_wd, exp_waddr;
    longint      a;
    bit          legal, inr, mis, err, has_read, has_write;
    int          off, wo;
    sz    = (f3[1:0] == 2'b00) ? 32'd1 : ((f3[1:0] == 2'b01) ? 32'd2 : 32'd4);
    legal = we ? (f3 inside {3'd0, 3'd1, 3'd2}) : (f3 inside {3'd0, 3'd1, 3'd2, 3'd4, 3'd5});
    a     = {32'd0, addr};
    inr   = (a >= longint'({32'd0, BASE})) && (a < longint'({32'd0, BASE}) + longint'(MEM_BYTES));
    mis   = (addr % sz) != 32'd0;
    err   = !legal || !inr || (TRAP && mis);
    eff   = addr - (addr % sz);
    exp_waddr = eff & 32'hFFFF_FFFC;
    exp_rd = 32'h0;
    exp_wd = 32'h0;
    if (!err) begin
      off = int'(eff - BASE);
      wo  = off & ~3;
      if (!we) begin
        case (f3)
          3'd0: exp_rd = {{24{ref_mem[off][7]}}, ref_mem[off]};
          3'd4: exp_rd = {24'h0, ref_mem[off]};
          3'd1: exp_rd = {{16{ref_mem[off+1][7]}}, ref_mem[off+1], ref_mem[off]};
          3'd5: exp_rd = {16'h0, ref_mem[off+1], ref_mem[off]};
          default: exp_rd = {ref_mem[off+3], ref_mem[off+2], ref_mem[off+1], ref_mem[off]};
        endcase
      end else begin
        for (int k = 0; k < int'(sz); k++) ref_mem[off+k] = wd[8*k +: 8];
        exp_wd = {ref_mem[wo+3], ref_mem[wo+2], ref_mem[wo+1], ref_mem[wo]};
      end
    end
    has_read  = !err && !(we && sz == 32'd4);
    has_write = !err && we;

    @(negedge clk);
    check_val("ready_idle", {31'd0, req_ready}, 32'd1);
    req_valid = 1'b1; req_we = we; req_funct3 = f3; req_addr = addr; req_wdata = wd;
    @(posedge clk); #1;
    req_valid = 1'b0;
    if (has_read) begin
      check_val("rd_code", {29'd0, mem_read}, 32'd5);
      check_val("rd_wcode", {29'd0, mem_write}, 32'd0);
      check_val("rd_addr", mem_addr, exp_waddr);
      check_val("rd_resp", {31'd0, resp_valid}, 32'd0);
      @(posedge clk); #1;
    end
    if (has_write) begin
      check_val("wr_code", {29'd0, mem_write}, 32'd4);
      check_val("wr_rcode", {29'd0, mem_read}, 32'd0);
      check_val("wr_addr", mem_addr, exp_waddr);
      check_val("wr_data", mem_wdata, exp_wd);
      check_val("wr_resp", {31'd0, resp_valid}, 32'd0);
      @(posedge clk); #1;
    end
    check_val("resp_valid", {31'd0, resp_valid}, 32'd1);
    check_val("resp_err", {31'd0, resp_err}, {31'd0, err});
    check_val("resp_rdata", resp_rdata, exp_rd);
    check_val("resp_ready", {31'd0, req_ready}, 32'd0);
    check_val("resp_strobes", {26'd0, mem_read, mem_write}, 32'd0);
    @(posedge clk); #1;
    check_val("post_valid", {31'd0, resp_valid}, 32'd0);
    check_val("post_ready", {31'd0, req_ready}, 32'd1);
  endtask

  initial begin
    logic        we;
    logic [2:0]  f3;
    logic [31:0] addr;
    logic [2:0]  ld_f3 [5];
    logic [2:0]  bad_f3 [3];
    ld_f3  = '{3'd0, 3'd1, 3'd2, 3'd4, 3'd5};
    bad_f3 = '{3'd3, 3'd6, 3'd7};
    for (int i = 0; i < 32768; i++) begin
      logic [31:0] w;
      w = init_word(i / 4);
      ref_mem[i] = w[8*(i%4) +: 8];
    end
    rst = 1'b1; req_valid = 1'b0; req_we = 1'b0; req_funct3 = 3'd0;
    req_addr = 32'h0; req_wdata = 32'h0; init_pulse = 1'b1;
    @(posedge clk); #1;
    init_pulse = 1'b0;
    @(posedge clk); #1;
    check_val("rst_ready", {31'd0, req_ready}, 32'd1);
    check_val("rst_resp", {30'd0, resp_valid, resp_err}, 32'd0);
    check_val("rst_rdata", resp_rdata, 32'd0);
    check_val("rst_codes", {26'd0, mem_read, mem_write}, 32'd0);
    check_val("rst_addr", mem_addr, 32'd0);
    check_val("rst_wdata", mem_wdata, 32'd0);
    rst = 1'b0;
    @(posedge clk); #1;

    run_txn(1'b0, 3'd0, 32'h8000_0013, 32'h0);           // LB -> FFFFFFAA
    run_txn(1'b0, 3'd5, 32'h8000_0012, 32'h0);           // LHU -> 0000AABB
    run_txn(1'b0, 3'd2, 32'h8000_0012, 32'h0);           // misaligned LW
    run_txn(1'b1, 3'd0, 32'h8000_0011, 32'h1234_5677);   // SB RMW
    run_txn(1'b0, 3'd2, 32'h8000_0010, 32'h0);
    run_txn(1'b1, 3'd2, 32'h8000_0020, 32'hDEAD_BEEF);   // SW, no read
    run_txn(1'b0, 3'd2, 32'h8000_0020, 32'h0);
    run_txn(1'b0, 3'd2, 32'h8000_8000, 32'h0);           // just past the top
    run_txn(1'b0, 3'd2, 32'h7FFF_FFFC, 32'h0);           // below base
    run_txn(1'b0, 3'd3, 32'h8000_0010, 32'h0);           // illegal funct3
    run_txn(1'b1, 3'd1, 32'h8000_7FFE, 32'h0000_BEEF);   // SH in last word
    run_txn(1'b0, 3'd1, 32'h8000_7FFE, 32'h0);

    // Reset during the READ cycle of a LB abandons it silently.
    @(negedge clk);
    req_valid = 1'b1; req_we = 1'b0; req_funct3 = 3'd0; req_addr = 32'h8000_0013;
    @(posedge clk); #1;
    req_valid = 1'b0;
    check_val("mid_rd_code", {29'd0, mem_read}, 32'd5);
    rst = 1'b1;
    @(posedge clk); #1;
    check_val("mid_rst_ready", {31'd0, req_ready}, 32'd1);
    check_val("mid_rst_resp", {31'd0, resp_valid}, 32'd0);
    check_val("mid_rst_codes", {26'd0, mem_read, mem_write}, 32'd0);
    rst = 1'b0;
    @(posedge clk); #1;
    check_val("mid_rst_noresp", {31'd0, resp_valid}, 32'd0);

    for (int n = 0; n < 400; n++) begin
      we = $urandom_range(0, 1) == 1;
      if ($urandom_range(0, 15) == 0) begin
        f3 = we ? 3'($urandom_range(3, 7)) : bad_f3[$urandom_range(0, 2)];
      end else begin
        f3 = we ? 3'($urandom_range(0, 2)) : ld_f3[$urandom_range(0, 4)];
      end
      case ($urandom_range(0, 9))
        0: begin
          case ($urandom_range(0, 3))
            0: addr = BASE - 32'($urandom_range(1, 16));
            1: addr = BASE + MEM_BYTES + 32'($urandom_range(0, 15));
            2: addr = 32'hFFFF_FFF0 + 32'($urandom_range(0, 15));
            default: addr = 32'($urandom_range(0, 64));
          endcase
        end
        1: addr = BASE + MEM_BYTES - 32'($urandom_range(1, 8));
        default: addr = BASE + 32'($urandom_range(0, 63));
      endcase
      run_txn(we, f3, addr, $urandom);
    end

    $display("Result: errors=%0d of %0d checks", n_err, n_chk);
    $finish;
  end

endmodule
